// File: rtl/dual_rail_pkg.sv
// Shared types and helpers for the dual-rail IO host: FSM states, spacer code, encoder.
package dual_rail_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL0,
        ST_EVAL1,
        ST_WAIT,
        ST_DONE,
        ST_SPACER,
        ST_FAULT
    } dr_state_e;

    // {t, f} rail pair carrying no data
    localparam logic [1:0] DR_SPACER = 2'b00;

    function automatic logic [1:0] dr_encode(input logic b);
        return {b, ~b};
    endfunction

endpackage

// File: rtl/dual_rail_checker.sv
// Combinational status of one dual-rail share bus: complete, spacer, or illegal t=f=1.
module dual_rail_checker #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_t,
    input  logic [WIDTH-1:0] i_f,
    input  logic [WIDTH-1:0] i_tristate,
    output logic             o_all_complete,
    output logic             o_all_spacer,
    output logic             o_any_invalid
);

    // A lane only counts as complete while the fabric is actually driving it.
    assign o_all_complete = &((i_t ^ i_f) & ~i_tristate);
    assign o_all_spacer   = ~|(i_t | i_f);
    assign o_any_invalid  = |(i_t & i_f);

endmodule

// File: rtl/dual_rail_io_host.sv
// Pad-side host for the dual-rail IO tiles: encodes share pairs, sequences the evaluate
// strobes and spacers, collects the completion-detected response and flags rail faults.
module dual_rail_io_host
    import dual_rail_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PRECH_CYCLES = 2,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic             UserCLK,
    input  logic             rst_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_share0,
    input  logic [WIDTH-1:0] tx_share1,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_share0,
    output logic [WIDTH-1:0] rx_share1,
    output logic             fault,
    output logic [WIDTH-1:0] O_top_0_t,
    output logic [WIDTH-1:0] O_top_0_f,
    output logic [WIDTH-1:0] O_top_1_t,
    output logic [WIDTH-1:0] O_top_1_f,
    output logic             prech1,
    output logic             prech2,
    input  logic [WIDTH-1:0] I_top_0_t,
    input  logic [WIDTH-1:0] I_top_0_f,
    input  logic [WIDTH-1:0] I_top_1_t,
    input  logic [WIDTH-1:0] I_top_1_f,
    input  logic [WIDTH-1:0] T_top,
    input  logic [WIDTH-1:0] F_masked1,
    input  logic [WIDTH-1:0] F_masked2,
    output logic             DR_fault
);

    localparam int CNT_MAX = (RESP_TIMEOUT > PRECH_CYCLES) ? RESP_TIMEOUT : PRECH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SPACER_LAST  = CNT_W'(PRECH_CYCLES - 1);

    dr_state_e        r_state;
    dr_state_e        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic [WIDTH-1:0] r_o0_t, r_o0_f, r_o1_t, r_o1_f;
    logic [WIDTH-1:0] r_rx0, r_rx1;

    logic w_c0_complete, w_c0_spacer, w_c0_invalid;
    logic w_c1_complete, w_c1_spacer, w_c1_invalid;
    logic w_resp_complete, w_resp_spacer, w_any_fault;

    dual_rail_checker #(.WIDTH(WIDTH)) u_chk0 (
        .i_t            (I_top_0_t),
        .i_f            (I_top_0_f),
        .i_tristate     (T_top),
        .o_all_complete (w_c0_complete),
        .o_all_spacer   (w_c0_spacer),
        .o_any_invalid  (w_c0_invalid)
    );

    dual_rail_checker #(.WIDTH(WIDTH)) u_chk1 (
        .i_t            (I_top_1_t),
        .i_f            (I_top_1_f),
        .i_tristate     (T_top),
        .o_all_complete (w_c1_complete),
        .o_all_spacer   (w_c1_spacer),
        .o_any_invalid  (w_c1_invalid)
    );

    assign w_resp_complete = w_c0_complete & w_c1_complete;
    assign w_resp_spacer   = w_c0_spacer & w_c1_spacer;

    assign w_any_fault = w_c0_invalid | w_c1_invalid
                       | (|(r_o0_t & r_o0_f)) | (|(r_o1_t & r_o1_f))
                       | ((r_state == ST_WAIT) && ((|F_masked1) || (|F_masked2)))
                       | ((r_state == ST_WAIT) && (r_cnt == TIMEOUT_LAST))
                       | ((r_state == ST_SPACER) && (r_cnt == SPACER_LAST) && !w_resp_spacer);

    // r_armed holds tx_ready low until the first edge after reset release.
    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
        end else begin
            // NOTE: all sequential state uses <= so every flop samples pre-edge values.
            r_state <= w_next;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves w_next unassigned (latch).
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (tx_valid && r_armed) w_next = ST_EVAL0;
            ST_EVAL0:  w_next = ST_EVAL1;
            ST_EVAL1:  w_next = ST_WAIT;
            ST_WAIT:   if (w_resp_complete) w_next = ST_DONE;
            ST_DONE:   if (rx_ready) w_next = ST_SPACER;
            ST_SPACER: if (r_cnt == SPACER_LAST) w_next = ST_IDLE;
            default:   w_next = ST_FAULT;
        endcase
        if (w_any_fault) w_next = ST_FAULT;
    end

    always_comb begin
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        prech1   = 1'b0;
        prech2   = 1'b0;
        fault    = 1'b0;
        case (r_state)
            ST_IDLE:  tx_ready = r_armed;
            ST_EVAL0: prech1   = 1'b1;
            ST_EVAL1, ST_WAIT: begin
                prech1 = 1'b1;
                prech2 = 1'b1;
            end
            ST_DONE: begin
                prech1   = 1'b1;
                prech2   = 1'b1;
                rx_valid = 1'b1;
            end
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT || r_state == ST_SPACER) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_o0_t <= '0;
            r_o0_f <= '0;
            r_o1_t <= '0;
            r_o1_f <= '0;
            r_rx0  <= '0;
            r_rx1  <= '0;
        end else begin
            if (w_next == ST_FAULT || (r_state == ST_DONE && w_next == ST_SPACER)) begin
                r_o0_t <= {WIDTH{DR_SPACER[1]}};
                r_o0_f <= {WIDTH{DR_SPACER[0]}};
                r_o1_t <= {WIDTH{DR_SPACER[1]}};
                r_o1_f <= {WIDTH{DR_SPACER[0]}};
            end else if (r_state == ST_IDLE && w_next == ST_EVAL0) begin
                for (int i = 0; i < WIDTH; i++) begin
                    {r_o0_t[i], r_o0_f[i]} <= dr_encode(tx_share0[i]);
                    {r_o1_t[i], r_o1_f[i]} <= dr_encode(tx_share1[i]);
                end
            end
            if (r_state == ST_WAIT && w_next == ST_DONE) begin
                r_rx0 <= I_top_0_t;
                r_rx1 <= I_top_1_t;
            end
        end
    end

    assign O_top_0_t = r_o0_t;
    assign O_top_0_f = r_o0_f;
    assign O_top_1_t = r_o1_t;
    assign O_top_1_f = r_o1_f;
    assign rx_share0 = r_rx0;
    assign rx_share1 = r_rx1;
    assign DR_fault  = fault;

endmodule

// File: tb/tb_dual_rail_io_host.sv
// Bench for dual_rail_io_host: a one-cycle echo tile model plus a queue-based reference
// of the share pairs the host should hand back, with timing rules as plain cycle counts.
module tb_dual_rail_io_host;

    localparam int W            = 8;
    localparam int PRECH_CYCLES = 2;
    localparam int RESP_TIMEOUT = 16;
    localparam int LATENCY      = 4;

    logic         UserCLK = 1'b0;
    logic         rst_n   = 1'b0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] tx_share0 = '0, tx_share1 = '0;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic [W-1:0] rx_share0, rx_share1;
    logic         fault;
    logic [W-1:0] O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f;
    logic         prech1, prech2;
    logic [W-1:0] I_top_0_t = '0, I_top_0_f = '0, I_top_1_t = '0, I_top_1_f = '0;
    logic [W-1:0] T_top = '0;
    logic [W-1:0] F_masked1 = '0, F_masked2 = '0;
    logic         DR_fault;

    // tile model state
    logic [W-1:0] resp_mask = '1;
    logic [W-1:0] p0_t = '0, p0_f = '0, p1_t = '0, p1_f = '0;
    bit           inject_bad = 0;
    bit           stuck_rail = 0;

    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];

    int checks = 0;
    int errors = 0;

    dual_rail_io_host #(
        .WIDTH        (W),
        .PRECH_CYCLES (PRECH_CYCLES),
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) dut (
        .UserCLK   (UserCLK),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_share0 (tx_share0),
        .tx_share1 (tx_share1),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_share0 (rx_share0),
        .rx_share1 (rx_share1),
        .fault     (fault),
        .O_top_0_t (O_top_0_t),
        .O_top_0_f (O_top_0_f),
        .O_top_1_t (O_top_1_t),
        .O_top_1_f (O_top_1_f),
        .prech1    (prech1),
        .prech2    (prech2),
        .I_top_0_t (I_top_0_t),
        .I_top_0_f (I_top_0_f),
        .I_top_1_t (I_top_1_t),
        .I_top_1_f (I_top_1_f),
        .T_top     (T_top),
        .F_masked1 (F_masked1),
        .F_masked2 (F_masked2),
        .DR_fault  (DR_fault)
    );

    always #5 UserCLK = ~UserCLK;

    // One clock: the tiles present what the host drove one edge earlier; masked-off lanes
    // stay tristated at spacer.
    task automatic tick();
        @(posedge UserCLK);
        #1;
        I_top_0_t = p0_t;
        I_top_0_f = p0_f;
        I_top_1_t = p1_t;
        I_top_1_f = p1_f;
        T_top     = ~resp_mask;
        if (inject_bad) begin
            I_top_1_t[0] = 1'b1;
            I_top_1_f[0] = 1'b1;
        end
        if (stuck_rail) begin
            I_top_0_t[5] = 1'b1;
            I_top_0_f[5] = 1'b0;
        end
        p0_t = O_top_0_t & resp_mask;
        p0_f = O_top_0_f & resp_mask;
        p1_t = O_top_1_t & resp_mask;
        p1_f = O_top_1_f & resp_mask;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        resp_mask  = '1;
        inject_bad = 0;
        stuck_rail = 0;
        p0_t = '0; p0_f = '0; p1_t = '0; p1_f = '0;
        exp0_q.delete();
        exp1_q.delete();
        repeat (2) tick();
        @(negedge UserCLK);
        rst_n = 1'b1;
    endtask

    task automatic wait_tx_ready(input string name);
        int n = 0;
        while (!tx_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: tx_ready=%b after %0d cycles, expected 1", name, tx_ready, n);
        end
    endtask

    // Offer a pair, wait for the response, hold it for 'hold' cycles, then consume it.
    // With spacer_stuck set a response rail is held at 1 through the spacer phase.
    task automatic run_txn(input logic [W-1:0] s0, input logic [W-1:0] s1, input int hold,
                           input bit spacer_stuck, input string name);
        int lat;
        int n;
        logic [W-1:0] e0, e1;
        wait_tx_ready(name);
        tx_share0 = s0;
        tx_share1 = s1;
        tx_valid  = 1'b1;
        exp0_q.push_back(s0);
        exp1_q.push_back(s1);
        tick();
        lat = 1;
        tx_valid = 1'b0;
        checks++;
        if ({prech1, prech2} !== 2'b10) begin
            errors++;
            $display("FAIL %s_prech_first: prech1/2=%b%b expected 10", name, prech1, prech2);
        end
        checks++;
        if ({O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f} !== {s0, ~s0, s1, ~s1}) begin
            errors++;
            $display("FAIL %s_encode: O_top0 t/f=%h/%h O_top1 t/f=%h/%h expected %h/%h %h/%h",
                     name, O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f, s0, ~s0, s1, ~s1);
        end
        tick();
        lat++;
        checks++;
        if ({prech1, prech2} !== 2'b11) begin
            errors++;
            $display("FAIL %s_prech_second: prech1/2=%b%b expected 11", name, prech1, prech2);
        end
        while (!rx_valid && lat < 40) begin
            tick();
            lat++;
        end
        // latency counts clock edges from the accepting edge up to rx_valid
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL %s_latency: rx_valid after %0d edges, expected %0d", name, lat, LATENCY);
        end
        e0 = exp0_q.pop_front();
        e1 = exp1_q.pop_front();
        checks++;
        if ({rx_valid, rx_share0, rx_share1, fault} !== {1'b1, e0, e1, 1'b0}) begin
            errors++;
            $display("FAIL %s_rx_data: valid=%b rx=%h/%h fault=%b expected 1 %h/%h 0",
                     name, rx_valid, rx_share0, rx_share1, fault, e0, e1);
        end
        for (int h = 0; h < hold; h++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({rx_valid, tx_ready, rx_share0, rx_share1} !== {1'b1, 1'b0, e0, e1}) begin
                errors++;
                $display("FAIL %s_hold%0d: valid=%b tx_ready=%b rx=%h/%h expected 1 0 %h/%h",
                         name, h, rx_valid, tx_ready, rx_share0, rx_share1, e0, e1);
            end
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        checks++;
        if ({rx_valid, prech1, prech2, O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f} !== '0) begin
            errors++;
            $display("FAIL %s_spacer_rails: valid=%b prech=%b%b rails=%h %h %h %h expected all 0",
                     name, rx_valid, prech1, prech2, O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f);
        end
        if (spacer_stuck) begin
            stuck_rail = 1;
            repeat (PRECH_CYCLES) tick();
            checks++;
            if ({fault, DR_fault, tx_ready} !== 3'b110) begin
                errors++;
                $display("FAIL %s_spacer_fault: fault=%b DR_fault=%b tx_ready=%b expected 1 1 0",
                         name, fault, DR_fault, tx_ready);
            end
        end else begin
            n = 0;
            while (!tx_ready && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (n !== PRECH_CYCLES || fault !== 1'b0) begin
                errors++;
                $display("FAIL %s_spacer_len: idle after %0d cycles fault=%b, expected %0d cycles fault=0",
                         name, n, fault, PRECH_CYCLES);
            end
        end
    endtask

    // Accept a pair and step until the host is in its response-wait phase.
    task automatic start_to_wait(input string name);
        wait_tx_ready(name);
        tx_share0 = W'($urandom);
        tx_share1 = W'($urandom);
        tx_valid  = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({tx_ready, rx_valid, fault, DR_fault, prech1, prech2} !== 6'b0 ||
            {O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f, rx_share0, rx_share1} !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b fault=%b dr=%b prech=%b%b rails=%h%h%h%h rx=%h/%h expected all 0",
                     tx_ready, rx_valid, fault, DR_fault, prech1, prech2,
                     O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f, rx_share0, rx_share1);
        end
        @(negedge UserCLK);
        rst_n = 1'b1;
        wait_tx_ready("reset");
    endtask

    task automatic test_nominal();
        run_txn(8'hA5, 8'h3C, 0, 0, "nominal");
    endtask

    task automatic test_backpressure();
        run_txn(W'($urandom), W'($urandom), 5, 0, "backpressure");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            run_txn(W'($urandom), W'($urandom), $urandom_range(0, 3), 0, $sformatf("b2b%0d", k));
        end
    endtask

    task automatic test_spacer_stuck();
        run_txn(W'($urandom), W'($urandom), 0, 1, "spacer_stuck");
    endtask

    task automatic test_timeout();
        int n = 0;
        resp_mask = 8'hF7;
        start_to_wait("timeout");
        tick();
        while (!fault && n < 100) begin
            checks++;
            if (rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_no_rx: rx_valid=%b at wait cycle %0d, expected 0", rx_valid, n);
            end
            tick();
            n++;
        end
        checks++;
        if (n !== RESP_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_cycles: fault after %0d cycles in wait, expected %0d", n, RESP_TIMEOUT);
        end
        repeat (3) tick();
        checks++;
        if ({fault, DR_fault, tx_ready, rx_valid, prech1, prech2} !== 6'b110000 ||
            {O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f} !== '0) begin
            errors++;
            $display("FAIL timeout_state: fault=%b dr=%b ready=%b valid=%b prech=%b%b rails=%h%h%h%h expected 1 1 0 0 00 spacer",
                     fault, DR_fault, tx_ready, rx_valid, prech1, prech2,
                     O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f);
        end
    endtask

    task automatic test_invalid_rail();
        bit saw_rx = 0;
        start_to_wait("invalid");
        inject_bad = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rx_valid) saw_rx = 1;
        end
        checks++;
        if ({fault, DR_fault, saw_rx, tx_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL invalid_rail: fault=%b dr=%b saw_rx=%b ready=%b expected 1 1 0 0",
                     fault, DR_fault, saw_rx, tx_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        resp_mask = '0;
        start_to_wait("mid_wait");
        repeat (3) tick();
        checks++;
        if ({prech1, prech2, rx_valid} !== 3'b110) begin
            errors++;
            $display("FAIL mid_wait_setup: prech=%b%b valid=%b expected 11 0", prech1, prech2, rx_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_ready, rx_valid, fault, DR_fault, prech1, prech2} !== 6'b0 ||
            {O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f} !== '0) begin
            errors++;
            $display("FAIL mid_wait_async_reset: ready=%b valid=%b fault=%b dr=%b prech=%b%b rails=%h%h%h%h expected all 0",
                     tx_ready, rx_valid, fault, DR_fault, prech1, prech2,
                     O_top_0_t, O_top_0_f, O_top_1_t, O_top_1_f);
        end
        apply_reset();
        run_txn(W'($urandom), W'($urandom), 1, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_back_to_back();
        test_spacer_stuck();
        apply_reset();
        test_timeout();
        apply_reset();
        test_invalid_rail();
        apply_reset();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
